// File: rtl/bus_arb_pkg.sv
// ----------------------------------------------------------------------------
// bus_arb_pkg
// Shared types and helpers for the snoop-bus tenure arbiter.
//   arb_state_e   : arbiter FSM states (idle, granted, bus owned, release)
//   REQ_READ/REQ_WB : meaning of a requester's req_type bit
//   bus_arb_clog2 : index width helper, never narrower than one bit
// ----------------------------------------------------------------------------
package bus_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GRANT   = 2'd1,
      ARB_BUSY    = 2'd2,
      ARB_RELEASE = 2'd3
   } arb_state_e;

   localparam logic REQ_READ = 1'b0;
   localparam logic REQ_WB   = 1'b1;

   // Width needed to hold an index in 0..n-1; a single bit at minimum so
   // that degenerate counters and grant ids still have a real port.
   function automatic int bus_arb_clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first set bit of vec at or
// above ptr, wrapping back to bit 0.
//   vec    : candidate requests (already class-masked by the parent)
//   ptr    : highest-priority index this cycle, always < N
//   onehot : one-hot winner, zero when nothing is set
//   idx    : winner index, zero when nothing is set
//   valid  : at least one candidate was set
// ----------------------------------------------------------------------------
module rr_pick
   import bus_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = bus_arb_clog2(N)
) (
   input  logic [N-1:0]  vec,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          valid
);

   logic [IW:0]   sum;
   logic [IW-1:0] cand;

   // Walk the N positions starting at ptr; the sum is one bit wider so the
   // wrap can be done with a single subtract even when N is not a power of 2.
   always_comb begin
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      sum    = '0;
      cand   = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr} + (IW+1)'(i);
         if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
         end
         cand = sum[IW-1:0];
         if (!valid && vec[cand]) begin
            valid        = 1'b1;
            idx          = cand;
            onehot[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_tenure_arbiter.sv
// ----------------------------------------------------------------------------
// bus_tenure_arbiter
// Round-robin, tenure-tracking arbiter for one shared snoop bus. Write-back
// requests beat reads; a grantee must claim the bus with hold inside a
// 2*CYCLE_RATIO cycle window or the grant is withdrawn.
//
// Parameters:
//   NUM_REQ     : number of requesters (2..8)
//   CYCLE_RATIO : bus/requester clock ratio, sets the hold-acquire window
//   MAX_TENURE  : longest allowed bus_active stretch (watchdog builds)
//
// Ports:
//   plusclk     : bus clock, rising-edge
//   rst         : asynchronous active-low reset
//   req         : per-requester level request
//   req_type    : per-requester type, 0 = read/fill, 1 = write-back
//   hold        : per-requester ownership claim (only grantee's bit used)
//   grant       : registered one-hot grant, or zero
//   grant_id    : registered index of current/last grantee
//   bus_active  : registered, high while the grantee owns the bus
//   timeout_err : one-cycle pulse when the watchdog forces a release
//
// Build option: define BUS_ARB_WATCHDOG_EN to bound tenures at MAX_TENURE
// cycles; otherwise tenure is unlimited and timeout_err is tied low.
// ----------------------------------------------------------------------------
module bus_tenure_arbiter
   import bus_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int CYCLE_RATIO = 1,
   parameter int MAX_TENURE  = 64
) (
   input  logic                                plusclk,
   input  logic                                rst,
   input  logic [NUM_REQ-1:0]                  req,
   input  logic [NUM_REQ-1:0]                  req_type,
   input  logic [NUM_REQ-1:0]                  hold,
   output logic [NUM_REQ-1:0]                  grant,
   output logic [bus_arb_clog2(NUM_REQ)-1:0]   grant_id,
   output logic                                bus_active,
   output logic                                timeout_err
);

   localparam int IW    = bus_arb_clog2(NUM_REQ);
   localparam int WIN_W = bus_arb_clog2(2 * CYCLE_RATIO);
   localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(2 * CYCLE_RATIO - 1);

   // Reject parameter sets the datapath widths were not sized for.
   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("bus_tenure_arbiter: NUM_REQ must be 2..8");
   end
   if (CYCLE_RATIO < 1) begin : g_bad_cycle_ratio
      $error("bus_tenure_arbiter: CYCLE_RATIO must be at least 1");
   end
   if (MAX_TENURE < 2) begin : g_bad_max_tenure
      $error("bus_tenure_arbiter: MAX_TENURE must be at least 2");
   end

   arb_state_e          state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [IW-1:0]       grant_id_q, grant_id_d;
   logic                bus_active_q, bus_active_d;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;

`ifdef BUS_ARB_WATCHDOG_EN
   localparam int TW = bus_arb_clog2(MAX_TENURE + 1);
   localparam logic [TW-1:0] TEN_LAST = TW'(MAX_TENURE - 1);
   logic [TW-1:0]       tenure_q, tenure_d;
   logic                timeout_err_q, timeout_err_d;
`endif

   logic [NUM_REQ-1:0]  wb_vec;
   logic [NUM_REQ-1:0]  pick_vec;
   logic [IW-1:0]       ptr_rel;
   logic [IW-1:0]       pick_ptr;
   logic [NUM_REQ-1:0]  pick_onehot;
   logic [IW-1:0]       pick_idx;
   logic                pick_valid;

   // Write-backs form their own priority class: when any is pending, reads
   // are hidden from the picker so dirty lines drain first.
   always_comb begin
      wb_vec = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         wb_vec[i] = req[i] && (req_type[i] == REQ_WB);
      end
      pick_vec = (|wb_vec) ? wb_vec : req;
   end

   // In RELEASE the pointer moves past the last grantee in the same cycle
   // that arbitration runs, so the freshly released requester ranks last.
   assign ptr_rel  = (grant_id_q == IW'(NUM_REQ - 1)) ? '0 : grant_id_q + IW'(1);
   assign pick_ptr = (state_q == ARB_RELEASE) ? ptr_rel : ptr_q;

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_rr_pick (
      .vec    (pick_vec),
      .ptr    (pick_ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

   // Next-state and output decode. Only the grantee's hold/req bits are
   // looked at once a grant is out; everyone else's inputs are ignored
   // until the next arbitration cycle.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      grant_id_d   = grant_id_q;
      bus_active_d = bus_active_q;
      ptr_d        = ptr_q;
      win_cnt_d    = win_cnt_q;
`ifdef BUS_ARB_WATCHDOG_EN
      tenure_d      = tenure_q;
      timeout_err_d = 1'b0;
`endif

      case (state_q)
         ARB_IDLE, ARB_RELEASE: begin
            if (state_q == ARB_RELEASE) begin
               ptr_d = ptr_rel;
            end
            if (pick_valid) begin
               state_d    = ARB_GRANT;
               grant_d    = pick_onehot;
               grant_id_d = pick_idx;
               win_cnt_d  = WIN_LOAD;
            end else begin
               state_d = ARB_IDLE;
            end
         end

         ARB_GRANT: begin
            // A claim on the very last window cycle still wins the bus.
            if (hold[grant_id_q]) begin
               state_d      = ARB_BUSY;
               bus_active_d = 1'b1;
`ifdef BUS_ARB_WATCHDOG_EN
               tenure_d     = '0;
`endif
            end else if (!req[grant_id_q] || (win_cnt_q == '0)) begin
               state_d = ARB_RELEASE;
               grant_d = '0;
            end else begin
               win_cnt_d = win_cnt_q - WIN_W'(1);
            end
         end

         ARB_BUSY: begin
            if (!hold[grant_id_q]) begin
               state_d      = ARB_RELEASE;
               grant_d      = '0;
               bus_active_d = 1'b0;
`ifdef BUS_ARB_WATCHDOG_EN
            end else if (tenure_q == TEN_LAST) begin
               state_d       = ARB_RELEASE;
               grant_d       = '0;
               bus_active_d  = 1'b0;
               timeout_err_d = 1'b1;
            end else begin
               tenure_d = tenure_q + TW'(1);
`endif
            end
         end

         default: begin
            state_d      = ARB_IDLE;
            grant_d      = '0;
            bus_active_d = 1'b0;
         end
      endcase
   end

   // Arbiter state register; reset clears every output straight away.
   always_ff @(posedge plusclk or negedge rst) begin
      if (!rst) begin
         state_q      <= ARB_IDLE;
         grant_q      <= '0;
         grant_id_q   <= '0;
         bus_active_q <= 1'b0;
         ptr_q        <= '0;
         win_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         grant_id_q   <= grant_id_d;
         bus_active_q <= bus_active_d;
         ptr_q        <= ptr_d;
         win_cnt_q    <= win_cnt_d;
      end
   end

`ifdef BUS_ARB_WATCHDOG_EN
   // Tenure watchdog counter and its one-shot error flag.
   always_ff @(posedge plusclk or negedge rst) begin
      if (!rst) begin
         tenure_q      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         tenure_q      <= tenure_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign grant      = grant_q;
   assign grant_id   = grant_id_q;
   assign bus_active = bus_active_q;

endmodule

// File: tb/tb_bus_tenure_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bus_tenure_arbiter
// Scoreboard bench. Each round picks a set of requesters and a behaviour for
// each (claim the bus, let the window lapse, drop req, or sit on hold). A
// transaction-level model orders the grants from the arbitration rules and
// works out every tenure's start/claim/end edge; those are queued, and an
// independent monitor pops one record per grant tenure seen on the DUT.
// Holds of non-owners and types of already-arbitrated requesters get random
// noise because the arbiter must ignore them.
// ----------------------------------------------------------------------------
module tb_bus_tenure_arbiter;

   localparam int N    = 4;
   localparam int CR   = 4;
   localparam int MAXT = 16;
   localparam int WIN  = 2 * CR;
   localparam int IW   = 2;
   localparam int RMAX = 256;

   logic          plusclk = 1'b0;
   logic          rst     = 1'b0;
   logic [N-1:0]  req     = '0;
   logic [N-1:0]  reqType = '0;
   logic [N-1:0]  hold    = '0;
   logic [N-1:0]  grant;
   logic [IW-1:0] grantId;
   logic          busActive;
   logic          timeoutErr;

`ifdef BUS_ARB_WATCHDOG_EN
   localparam bit WD_ON = 1'b1;
`else
   localparam bit WD_ON = 1'b0;
`endif

   bus_tenure_arbiter #(
      .NUM_REQ     (N),
      .CYCLE_RATIO (CR),
      .MAX_TENURE  (MAXT)
   ) dut (
      .plusclk     (plusclk),
      .rst         (rst),
      .req         (req),
      .req_type    (reqType),
      .hold        (hold),
      .grant       (grant),
      .grant_id    (grantId),
      .bus_active  (busActive),
      .timeout_err (timeoutErr)
   );

   // Free-running bus clock.
   always #5 plusclk = ~plusclk;

   // Index of the most recent rising edge; stable when read at negedge.
   int edgeCount = 0;
   always @(posedge plusclk) edgeCount <= edgeCount + 1;

   int passCount  = 0;
   int checkCount = 0;
   int strayCount = 0;

   typedef struct {
      int id;
      int start;
      int actStart;
      int finish;
      int timeout;
   } tenure_t;

   tenure_t expQ[$];

   logic [N-1:0] planReq     [RMAX];
   logic [N-1:0] planHold    [RMAX];
   logic [N-1:0] planOwn     [RMAX];
   logic [N-1:0] planTypeFix [RMAX];
   logic [N-1:0] roundType;
   int           roundLen;
   int           modelPtr = 0;

   // Behaviour per requester: 0 claim after dly for len cycles, 1 never
   // claim (window lapses), 2 drop req after dly, 3 hold stuck high.
   int kindOf [N];
   int dlyOf  [N];
   int lenOf  [N];

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, wanted %0d", name, actual, expected);
   endtask

   task automatic setAll(input int kind, input int dly, input int len);
      for (int r = 0; r < N; r++) begin
         kindOf[r] = kind;
         dlyOf[r]  = dly;
         lenOf[r]  = len;
      end
   endtask

   // Transaction model: order winners by class then round-robin from the
   // pointer, and lay out each tenure on the round's edge timeline.
   task automatic planRound(input logic [N-1:0] reqSet, input logic [N-1:0] typeSet, input int base);
      logic [N-1:0] remaining;
      logic [N-1:0] cand;
      int ptr, g, e, act, win, to, pos;
      for (int t = 0; t < RMAX; t++) begin
         planReq[t]     = '0;
         planHold[t]    = '0;
         planOwn[t]     = '0;
         planTypeFix[t] = '0;
      end
      roundType = typeSet;
      remaining = reqSet;
      ptr = modelPtr;
      g   = 0;
      e   = 0;
      while (remaining != '0) begin
         cand = ((remaining & typeSet) != '0) ? (remaining & typeSet) : remaining;
         win  = -1;
         for (int i = 0; i < N; i++) begin
            pos = (ptr + i) % N;
            if (win < 0 && cand[pos]) win = pos;
         end
         to  = 0;
         act = -1;
         case (kindOf[win])
            0: begin act = g + 1 + dlyOf[win]; e = act + lenOf[win]; end
            1: e = g + WIN;
            2: e = g + 1 + dlyOf[win];
            default: begin act = g + 1 + dlyOf[win]; e = act + MAXT; to = 1; end
         endcase
         for (int t = 0; t <= e; t++) begin
            if (kindOf[win] != 2 || t < e) planReq[t][win] = 1'b1;
            if (t <= g) planTypeFix[t][win] = 1'b1;
            if (t > g) begin
               planOwn[t][win] = 1'b1;
               if (act >= 0 && t >= act && (t < e || to == 1)) planHold[t][win] = 1'b1;
            end
         end
         expQ.push_back('{win, base + g, (act < 0) ? -1 : base + act, base + e, to});
         remaining[win] = 1'b0;
         ptr = (win + 1) % N;
         g   = e + 1;
      end
      roundLen = e + 3;
      modelPtr = ptr;
   endtask

   task automatic applyStimulus(input int t);
      req     = planReq[t];
      hold    = (planHold[t] & planOwn[t]) | (N'($urandom) & ~planOwn[t]);
      reqType = (roundType & planTypeFix[t]) | (N'($urandom) & ~planTypeFix[t]);
   endtask

   task automatic runRound(input logic [N-1:0] reqSet, input logic [N-1:0] typeSet);
      int base;
      @(negedge plusclk);
      base = edgeCount + 1;
      planRound(reqSet, typeSet, base);
      for (int t = 0; t < roundLen; t++) begin
         if (t > 0) @(negedge plusclk);
         applyStimulus(t);
      end
   endtask

   task automatic randomRound();
      for (int r = 0; r < N; r++) begin
         kindOf[r] = WD_ON ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 2));
         dlyOf[r]  = int'($urandom_range(0, WIN - 1));
         lenOf[r]  = int'($urandom_range(1, MAXT));
      end
      runRound(N'($urandom_range(1, (1 << N) - 1)), N'($urandom));
   endtask

   // Reset while a requester owns the bus; outputs must clear before the
   // next clock edge, and arbitration restarts from pointer 0.
   task automatic resetMidBusy();
      @(negedge plusclk);
      req = 4'b0100; hold = '0; reqType = '0;
      @(negedge plusclk);
      hold = 4'b0100;
      @(negedge plusclk);
      @(negedge plusclk);
      checkOutput("busy_before_reset", int'(busActive), 1);
      checkOutput("grant_id_before_reset", int'(grantId), 2);
      #2 rst = 1'b0;
      #1;
      checkOutput("reset_grant", int'(grant), 0);
      checkOutput("reset_bus_active", int'(busActive), 0);
      checkOutput("reset_grant_id", int'(grantId), 0);
      @(negedge plusclk);
      req = '0; hold = '0;
      #2 rst = 1'b1;
      modelPtr = 0;
   endtask

   // Monitor: one record per grant tenure, closed when grant falls.
   initial begin
      logic [N-1:0] prevGrant;
      logic [N-1:0] curGrant;
      int curId, curStart, curAct, curChg;
      tenure_t ex;
      prevGrant = '0;
      curGrant  = '0;
      curId = 0; curStart = 0; curAct = -1; curChg = 0;
      forever begin
         @(negedge plusclk);
         if (!rst) begin
            prevGrant = '0;
         end else begin
            if (grant != '0 && prevGrant == '0) begin
               curId    = int'(grantId);
               curGrant = grant;
               curStart = edgeCount;
               curAct   = -1;
               curChg   = 0;
            end else if (grant != '0 && grant != prevGrant) begin
               curChg = 1;
            end
            if (grant != '0 && busActive && curAct < 0) curAct = edgeCount;
            if (grant != '0 && !busActive && curAct >= 0) curChg = 1;
            if (grant == '0 && prevGrant != '0) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_tenure", curId, -1);
               end else begin
                  ex = expQ.pop_front();
                  checkOutput("grant_id", curId, ex.id);
                  checkOutput("grant_onehot", int'(curGrant), 1 << ex.id);
                  checkOutput("grant_start", curStart, ex.start);
                  checkOutput("active_start", curAct, ex.actStart);
                  checkOutput("tenure_end", edgeCount, ex.finish);
                  checkOutput("timeout_pulse", int'(timeoutErr), ex.timeout);
                  checkOutput("tenure_stable", curChg, 0);
               end
            end else if (timeoutErr) begin
               strayCount++;
            end
            if (grant == '0 && busActive) strayCount++;
            prevGrant = grant;
         end
      end
   end

   initial begin
      repeat (3) @(negedge plusclk);
      checkOutput("rst_grant", int'(grant), 0);
      checkOutput("rst_grant_id", int'(grantId), 0);
      checkOutput("rst_bus_active", int'(busActive), 0);
      checkOutput("rst_timeout", int'(timeoutErr), 0);
      #1 rst = 1'b1;

      // Fairness: everyone, reads, 3-cycle tenures -> 0,1,2,3.
      setAll(0, 0, 3);
      runRound(4'b1111, 4'b0000);
      // Write-back priority: 2 first, then 3,0,1.
      runRound(4'b1111, 4'b0100);
      // Single requester with a longer tenure.
      setAll(0, 1, 8);
      runRound(4'b0100, 4'b0000);
      // Window lapse on 1 (write-back wins first), then 2 claims on the
      // last window cycle.
      kindOf[1] = 1;
      kindOf[2] = 0; dlyOf[2] = WIN - 1; lenOf[2] = 4;
      runRound(4'b0110, 4'b0010);
      // Requester gives up by dropping req.
      kindOf[0] = 2; dlyOf[0] = WIN - 1;
      runRound(4'b0001, 4'b0000);
`ifdef BUS_ARB_WATCHDOG_EN
      // Stuck hold forces a timeout; a tenure of exactly MAXT does not.
      kindOf[0] = 3; dlyOf[0] = 0;
      kindOf[1] = 0; dlyOf[1] = 0; lenOf[1] = MAXT;
      runRound(4'b0011, 4'b0000);
`endif
      // Move the pointer off zero, then reset mid-tenure.
      setAll(0, 0, 2);
      runRound(4'b0010, 4'b0000);
      resetMidBusy();
      runRound(4'b1001, 4'b0000);

      repeat (40) randomRound();

      @(negedge plusclk);
      req = '0; hold = '0; reqType = '0;
      repeat (5) @(negedge plusclk);
      checkOutput("queue_drained", expQ.size(), 0);
      checkOutput("stray_events", strayCount, 0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
